// File: rtl/sample_stream_ctrl.sv
// rtl/sample_stream_ctrl.sv - sample clock sequencer and packetiser for the counter sample generator
module sample_stream_ctrl #(
   parameter int C_M_AXIS_DATA_WIDTH = 32,
   parameter int C_DIV_WIDTH         = 16,
   parameter int C_LEN_WIDTH         = 16
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic                           start,
   input  logic                           stop,
   input  logic [C_DIV_WIDTH-1:0]         clk_div,
   input  logic [C_LEN_WIDTH-1:0]         period_len,
   output logic                           gen_sample_clk,
   output logic                           gen_enable,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0] gen_data,
   input  logic                           gen_valid,
   output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic                           busy,
   output logic                           overflow
);

   localparam logic [C_DIV_WIDTH-1:0] DIV_ONE = {{(C_DIV_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [C_LEN_WIDTH-1:0] LEN_ONE = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 state;
   logic [C_DIV_WIDTH-1:0] div_shadow;
   logic [C_LEN_WIDTH-1:0] len_shadow;
   logic [C_DIV_WIDTH-1:0] div_cnt;
   logic [C_LEN_WIDTH-1:0] beat_cnt;
   logic                   stop_pending;

   logic                   handshake;
   logic                   buf_free;
   logic                   capture;
   logic                   drop;
   logic                   last_beat;
   logic [C_LEN_WIDTH-1:0] beat_cnt_nxt;
   logic [C_LEN_WIDTH-1:0] beat_cnt_after;
   logic                   stop_req;
   logic                   stop_now;
   logic                   div_tc;
   logic [C_DIV_WIDTH-1:0] div_eff;
   logic [C_LEN_WIDTH-1:0] len_eff;

   // Capture, packet-boundary and divider decode shared by the FSM and the stream buffer
   always_comb begin
      handshake      = m_axis_tvalid && m_axis_tready;
      // The single buffer entry can take a new sample if it is empty or draining this cycle.
      buf_free       = !m_axis_tvalid || m_axis_tready;
      capture        = (state == S_RUN) && gen_valid && buf_free;
      drop           = (state == S_RUN) && gen_valid && !buf_free;
      last_beat      = (beat_cnt == (len_shadow - LEN_ONE));
      beat_cnt_nxt   = last_beat ? '0 : (beat_cnt + LEN_ONE);
      beat_cnt_after = capture ? beat_cnt_nxt : beat_cnt;
      stop_req       = stop || stop_pending;
      // Leave RUN only when the packet position after this cycle is a boundary, so a sample
      // loading alongside the stop pulse can never open a packet that would be cut short.
      stop_now       = (state == S_RUN) && stop_req && (beat_cnt_after == '0);
      div_tc         = (div_cnt == (div_shadow - DIV_ONE));
      div_eff        = (clk_div == '0) ? DIV_ONE : clk_div;
      len_eff        = (period_len == '0) ? LEN_ONE : period_len;
   end

   // Sequencer: state, generator clock/enable, stop bookkeeping and sticky overflow
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         gen_enable     <= 1'b0;
         gen_sample_clk <= 1'b0;
         div_cnt        <= '0;
         div_shadow     <= '0;
         len_shadow     <= '0;
         stop_pending   <= 1'b0;
         overflow       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  div_shadow     <= div_eff;
                  len_shadow     <= len_eff;
                  div_cnt        <= '0;
                  gen_sample_clk <= 1'b0;
                  gen_enable     <= 1'b1;
                  overflow       <= 1'b0;
                  stop_pending   <= 1'b0;
                  busy           <= 1'b1;
                  state          <= S_RUN;
               end
            end

            S_RUN: begin
               if (div_tc) begin
                  div_cnt        <= '0;
                  gen_sample_clk <= ~gen_sample_clk;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
               if (stop) begin
                  stop_pending <= 1'b1;
               end
               if (drop) begin
                  overflow <= 1'b1;
               end
               // Placed last so the forced-low sample clock overrides a divider toggle.
               if (stop_now) begin
                  gen_enable     <= 1'b0;
                  gen_sample_clk <= 1'b0;
                  state          <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               if (!m_axis_tvalid) begin
                  stop_pending <= 1'b0;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: begin
               gen_enable     <= 1'b0;
               gen_sample_clk <= 1'b0;
               stop_pending   <= 1'b0;
               busy           <= 1'b0;
               state          <= S_IDLE;
            end
         endcase
      end
   end

   // Position of the next captured sample within its packet
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         beat_cnt <= '0;
      end else if ((state == S_IDLE) && start) begin
         beat_cnt <= '0;
      end else if (capture) begin
         beat_cnt <= beat_cnt_nxt;
      end
   end

   // One-entry stream buffer: data and TLAST are only rewritten on capture, so they hold during stalls
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
      end else if (capture) begin
         m_axis_tdata  <= gen_data;
         m_axis_tlast  <= last_beat;
         m_axis_tvalid <= 1'b1;
      end else if (handshake) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// tb/tb_sample_stream_ctrl.sv - directed self-checking bench for sample_stream_ctrl
module tb_sample_stream_ctrl;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        start;
   logic        stop;
   logic [15:0] clk_div;
   logic [15:0] period_len;
   logic        gen_sample_clk;
   logic        gen_enable;
   logic [31:0] gen_data;
   logic        gen_valid;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        busy;
   logic        overflow;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          stab_err = 0;
   int          gen_cnt = 1;
   int          s_cyc;
   logic [32:0] beat_q[$];
   int          rise_q[$];

   sample_stream_ctrl #(
      .C_M_AXIS_DATA_WIDTH(32),
      .C_DIV_WIDTH(16),
      .C_LEN_WIDTH(16)
   ) dut (
      .ACLK(ACLK),
      .ARESETN(ARESETN),
      .start(start),
      .stop(stop),
      .clk_div(clk_div),
      .period_len(period_len),
      .gen_sample_clk(gen_sample_clk),
      .gen_enable(gen_enable),
      .gen_data(gen_data),
      .gen_valid(gen_valid),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .busy(busy),
      .overflow(overflow)
   );

   initial forever #5 ACLK = ~ACLK;

   initial forever begin
      @(posedge ACLK);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Counter generator: one-cycle valid after each rising sample clock edge while enabled
   initial begin
      logic prev_sclk;
      prev_sclk = 1'b0;
      gen_valid = 1'b0;
      gen_data  = '0;
      forever begin
         @(posedge ACLK);
         #1;
         if (gen_enable && gen_sample_clk && !prev_sclk) begin
            gen_valid = 1'b1;
            gen_data  = gen_cnt;
            gen_cnt++;
         end else begin
            gen_valid = 1'b0;
         end
         prev_sclk = gen_sample_clk;
      end
   end

   // Stream monitor: records handshakes and sample clock rises, counts stall instability
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic        prev_last;
      logic        mon_prev_sclk;
      prev_stall    = 1'b0;
      prev_data     = '0;
      prev_last     = 1'b0;
      mon_prev_sclk = 1'b0;
      forever begin
         @(negedge ACLK);
         if (prev_stall) begin
            if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === prev_data && m_axis_tlast === prev_last))
               stab_err++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready && ARESETN;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready)
            beat_q.push_back({m_axis_tlast, m_axis_tdata});
         if (gen_sample_clk && !mon_prev_sclk)
            rise_q.push_back(cyc);
         mon_prev_sclk = gen_sample_clk;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge ACLK);
         #1;
      end
   endtask

   task automatic do_start(input logic [15:0] d, input logic [15:0] l);
      clk_div    = d;
      period_len = l;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
      s_cyc      = cyc;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget, input string tag);
      int k = 0;
      while (beat_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 64'(beat_q.size() >= n), 64'd1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int k = 0;
      while (!m_axis_tvalid && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 64'(m_axis_tvalid), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
      check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
      check({tag, "_gen_enable"}, 64'(gen_enable), 64'd0);
      check({tag, "_sclk"}, 64'(gen_sample_clk), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
   endtask

   initial begin
      int k;
      ARESETN       = 1'b0;
      start         = 1'b0;
      stop          = 1'b0;
      clk_div       = '0;
      period_len    = '0;
      m_axis_tready = 1'b0;

      // Reset state
      tick(2);
      check_reset_outputs("rst");
      ARESETN = 1'b1;
      tick(1);

      // div=2, len=4, always ready: two packets of four beats
      m_axis_tready = 1'b1;
      gen_cnt = 1;
      beat_q.delete();
      rise_q.delete();
      do_start(16'd2, 16'd4);
      check("t1_busy", 64'(busy), 64'd1);
      check("t1_enable", 64'(gen_enable), 64'd1);
      check("t1_sclk_low_entry", 64'(gen_sample_clk), 64'd0);
      wait_beats(8, 80, "t1_beats_timeout");
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_data%0d", i), 64'(beat_q[i][31:0]), 64'(i + 1));
         check($sformatf("t1_last%0d", i), 64'(beat_q[i][32]), 64'((i % 4) == 3));
      end
      check("t1_first_rise", 64'(rise_q[0] - s_cyc), 64'd2);
      check("t1_sclk_period", 64'(rise_q[1] - rise_q[0]), 64'd4);
      check("t1_overflow", 64'(overflow), 64'd0);
      pulse_stop();
      wait_idle(40, "t1_idle_timeout");
      tick(10);
      check("t1_no_extra_beats", 64'(beat_q.size()), 64'd8);
      check("t1_enable_off", 64'(gen_enable), 64'd0);

      // div=0, len=0 behave as 1: period 2, every beat is last
      gen_cnt = 1;
      beat_q.delete();
      rise_q.delete();
      do_start(16'd0, 16'd0);
      wait_beats(4, 40, "t2_beats_timeout");
      check("t2_first_rise", 64'(rise_q[0] - s_cyc), 64'd1);
      check("t2_sclk_period", 64'(rise_q[1] - rise_q[0]), 64'd2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_data%0d", i), 64'(beat_q[i][31:0]), 64'(i + 1));
         check($sformatf("t2_last%0d", i), 64'(beat_q[i][32]), 64'd1);
      end
      pulse_stop();
      wait_idle(40, "t2_idle_timeout");
      check("t2_overflow", 64'(overflow), 64'd0);
      check("t2_final_last", 64'(beat_q[beat_q.size() - 1][32]), 64'd1);

      // div=1, len=8, backpressure after first beat causes drops
      m_axis_tready = 1'b0;
      gen_cnt = 1;
      beat_q.delete();
      do_start(16'd1, 16'd8);
      wait_valid(20, "t3_valid_timeout");
      check("t3_first_data", 64'(m_axis_tdata), 64'd1);
      tick(6);
      check("t3_held_data", 64'(m_axis_tdata), 64'd1);
      check("t3_held_valid", 64'(m_axis_tvalid), 64'd1);
      check("t3_held_last", 64'(m_axis_tlast), 64'd0);
      check("t3_overflow", 64'(overflow), 64'd1);
      m_axis_tready = 1'b1;
      wait_beats(8, 60, "t3_beats_timeout");
      check("t3_beat0", 64'(beat_q[0][31:0]), 64'd1);
      check("t3_dropped", 64'(beat_q[1][31:0] > 32'd2), 64'd1);
      check("t3_resume_contig", 64'(beat_q[7][31:0] - beat_q[1][31:0]), 64'd6);
      for (int i = 0; i < 8; i++)
         check($sformatf("t3_last%0d", i), 64'(beat_q[i][32]), 64'(i == 7));
      pulse_stop();
      wait_idle(100, "t3_idle_timeout");
      check("t3_whole_packets", 64'(beat_q.size() % 8), 64'd0);
      check("t3_final_last", 64'(beat_q[beat_q.size() - 1][32]), 64'd1);
      check("t3_overflow_held", 64'(overflow), 64'd1);
      check("t3_stall_stable", 64'(stab_err), 64'd0);

      // len=4, stop after the second beat completes the packet
      m_axis_tready = 1'b1;
      gen_cnt = 1;
      beat_q.delete();
      do_start(16'd2, 16'd4);
      wait_beats(2, 40, "t4_beats_timeout");
      pulse_stop();
      k = 0;
      while (!(m_axis_tvalid && m_axis_tlast) && k < 40) begin
         tick(1);
         k++;
      end
      check("t4_last_seen", 64'(m_axis_tvalid && m_axis_tlast), 64'd1);
      check("t4_enable_off", 64'(gen_enable), 64'd0);
      check("t4_sclk_off", 64'(gen_sample_clk), 64'd0);
      check("t4_busy_drain", 64'(busy), 64'd1);
      wait_idle(20, "t4_idle_timeout");
      tick(12);
      check("t4_beat_count", 64'(beat_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_data%0d", i), 64'(beat_q[i][31:0]), 64'(i + 1));
         check($sformatf("t4_last%0d", i), 64'(beat_q[i][32]), 64'(i == 3));
      end

      // stop on a packet boundary with a stalled pending beat
      m_axis_tready = 1'b0;
      gen_cnt = 1;
      beat_q.delete();
      do_start(16'd4, 16'd1);
      wait_valid(30, "t5_valid_timeout");
      pulse_stop();
      check("t5_enable_off", 64'(gen_enable), 64'd0);
      check("t5_busy", 64'(busy), 64'd1);
      check("t5_valid_held", 64'(m_axis_tvalid), 64'd1);
      tick(1);
      check("t5_busy_stall", 64'(busy), 64'd1);
      tick(1);
      m_axis_tready = 1'b1;
      tick(2);
      check("t5_idle", 64'(busy), 64'd0);
      check("t5_beat_count", 64'(beat_q.size()), 64'd1);
      check("t5_data", 64'(beat_q[0][31:0]), 64'd1);
      check("t5_last", 64'(beat_q[0][32]), 64'd1);

      // reset mid-run with a pending beat and overflow set
      m_axis_tready = 1'b0;
      gen_cnt = 1;
      beat_q.delete();
      do_start(16'd2, 16'd4);
      k = 0;
      while (!overflow && k < 40) begin
         tick(1);
         k++;
      end
      check("t6_overflow_pre", 64'(overflow), 64'd1);
      check("t6_valid_pre", 64'(m_axis_tvalid), 64'd1);
      ARESETN = 1'b0;
      tick(1);
      check_reset_outputs("t6_rst");
      ARESETN = 1'b1;
      tick(1);
      m_axis_tready = 1'b1;
      gen_cnt = 1;
      beat_q.delete();
      do_start(16'd2, 16'd4);
      check("t6_overflow_clear", 64'(overflow), 64'd0);
      wait_beats(4, 40, "t6_beats_timeout");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t6_data%0d", i), 64'(beat_q[i][31:0]), 64'(i + 1));
         check($sformatf("t6_last%0d", i), 64'(beat_q[i][32]), 64'(i == 3));
      end
      pulse_stop();
      wait_idle(40, "t6_idle_timeout");
      check("all_stall_stable", 64'(stab_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sample_stream_ctrl.md
Name: sample_stream_ctrl

Overview:
Sequencer and packetiser for the counter sample generator. It produces the generator's sample_clk and enable from an ACLK divider. It captures each generator output pulse into a one-entry AXI4-Stream master buffer and marks TLAST every period_len samples, giving one DMA cyclic period per packet. It also handles start/stop sequencing so that streaming stops only on a packet boundary, and it flags samples lost to backpressure.

Parameters:
C_M_AXIS_DATA_WIDTH, 32, sample/TDATA width
C_DIV_WIDTH, 16, width of clock divider setting
C_LEN_WIDTH, 16, width of packet length setting

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous, active-low reset
start  in  1  single-cycle start pulse
stop  in  1  single-cycle stop request pulse
clk_div  in  C_DIV_WIDTH  sample_clk half-period in ACLK cycles; 0 is treated as 1
period_len  in  C_LEN_WIDTH  samples per packet; 0 is treated as 1
gen_sample_clk  out  1  sample clock to generator
gen_enable  out  1  generator enable
gen_data  in  C_M_AXIS_DATA_WIDTH  generator sample
gen_valid  in  1  generator one-cycle valid pulse
m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  packet end
busy  out  1  high whenever state is not IDLE
overflow  out  1  sticky: a sample was dropped

Behaviour:
- Clock ACLK. Reset ARESETN is synchronous and active-low. Under reset all outputs are 0, the state is IDLE, all counters are 0, stop_pending is 0 and the buffer is empty.
- Reset mid-operation: the buffered beat is discarded and TVALID drops in the next cycle. This is the only permitted TVALID withdrawal.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - gen_enable=0, gen_sample_clk=0, gen_valid ignored.
  - On start, latch max(clk_div,1) and max(period_len,1) into shadow registers, clear overflow, beat_cnt and the divider, then go to RUN.
  - stop in IDLE is ignored. If start and stop arrive in the same cycle, start wins.
- RUN:
  - gen_enable=1.
  - The divider counts 0..div-1. At terminal count it toggles gen_sample_clk and restarts.
  - gen_sample_clk is low on RUN entry, so the first rising edge falls div cycles after entry. The period is 2*div cycles at 50% duty.
  - start in RUN or DRAIN is ignored. Config inputs are sampled only at start.
- Capture:
  - On gen_valid in RUN, the sample loads into the buffer if the buffer is empty or the current beat is handshaking in the same cycle (TVALID&&TREADY).
  - Otherwise the sample is dropped, overflow is set, and beat_cnt is not advanced.
  - TLAST is registered with the data: it is 1 when beat_cnt == len-1. beat_cnt then wraps to 0; otherwise it increments.
- Stream rules:
  - TDATA and TLAST are held stable while TVALID && !TREADY.
  - TVALID clears after a handshake unless the same cycle reloads the buffer.
  - Throughput is one beat per cycle.
- Stop:
  - stop in RUN sets stop_pending.
  - If beat_cnt==0 when stop arrives, or on the cycle a TLAST sample loads while stop_pending is set, the block goes to DRAIN.
  - A stop is therefore never followed by a truncated packet.
  - Repeated stop pulses have no further effect.
- DRAIN:
  - gen_enable=0, gen_sample_clk forced to 0, divider held, gen_valid ignored.
  - Stay in DRAIN until the buffer is empty, then go to IDLE the next cycle and clear stop_pending.
  - overflow holds its value until the next start.
- Widths: counters are unsigned with no saturation. period_len up to 2^C_LEN_WIDTH-1 is legal.

Test Plan:
- clk_div=2, period_len=4, TREADY=1, start; generator counts from 1 -> gen_sample_clk period 4 cycles; beats 1,2,3,4 with TLAST on 4, then 5..8 with TLAST on 8; overflow=0.
- clk_div=0, period_len=0 -> behaves as div=1, len=1: sample_clk period 2 cycles, every beat has TLAST=1.
- clk_div=1, len=8, TREADY held low for 6 cycles after the first beat -> beat 1 held stable, later samples dropped, overflow=1. After release the stream resumes and TLAST lands on the 8th accepted beat.
- len=4, stop pulse after the 2nd beat -> beats 3 and 4 still sent, TLAST on 4, then gen_enable=0, busy falls after the last handshake; no 5th beat.
- stop with beat_cnt==0, TREADY low for 3 cycles -> immediate DRAIN, gen_enable=0 in the next cycle, busy stays 1 until the pending beat handshakes, then IDLE.
- ARESETN low for 1 cycle mid-RUN with TVALID=1 -> next cycle all outputs 0, state IDLE. A new start restarts with beat_cnt=0 and overflow cleared.
